bus_xfer_ctrl: RTL
==================

Name: bus_xfer_ctrl

Overview:
Sequencer that initiates register-to-register transfers on the shared 16-bit tri-state common bus. It consumes transfer requests over a valid/ready handshake and generates the per-register control strobes: one-hot read enable to the source and load/inc/clear to the destination. Those strobes drive the bus-attached registers (address, data, accumulator, ...), whose outputs are registered and tri-stated while their read enable is low. One instance per bus; it is the only block allowed to drive register read enables.

Parameters:
NREG, 8, number of bus-attached registers; register indices are 0..NREG-1.
IDXW, 3, index width; must satisfy 2**IDXW >= NREG.
WIDTH, 16, bus data width.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  transfer request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_op  input  2  00 MOVE src->dst, 01 INC dst, 10 CLR dst, 11 reserved
req_src  input  IDXW  source register index (MOVE only)
req_dst  input  IDXW  destination register index
read_en  output  NREG  one-hot source read enable (registered)
load_en  output  NREG  one-hot destination load (registered)
inc_en  output  NREG  one-hot destination increment (registered)
clr_en  output  NREG  one-hot destination clear (registered)
bus_in  input  WIDTH  common bus value, sampled for observability
xfer_data  output  WIDTH  last value moved across the bus
done  output  1  one-cycle pulse: operation completed
err  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset (async, rst_n=0): state=IDLE. read_en, load_en, inc_en, clr_en all 0. done=0, err=0, xfer_data=0. The bus is therefore undriven.
- Accept: the handshake completes on a rising edge with req_valid && req_ready. op, src and dst are latched at that edge. req_ready=0 in every state except IDLE.
- Validation at accept. The request is rejected when any of these holds:
  - op=11;
  - dst>=NREG;
  - for MOVE, src>=NREG or src==dst.
- On reject: next state ERR, with err=1 for exactly one cycle. No strobes, xfer_data unchanged, then return to IDLE.
- MOVE, in the states following accept:
  - DRIVE (1 cycle): read_en[src]=1. The source captures onto its output at the end-of-cycle edge.
  - LOAD (1 cycle): read_en[src]=1 held, load_en[dst]=1. The destination captures the bus at the end-of-cycle edge, and xfer_data<=bus_in at that same edge.
  - DONE (1 cycle): all strobes 0, done=1. The source releases the bus.
  - Latency: accept edge to done high is 3 cycles. The next accept can occur at the edge ending DONE+1, i.e. the controller returns to IDLE after DONE.
- INC / CLR:
  - UNARY (1 cycle): inc_en[dst]=1 or clr_en[dst]=1.
  - DONE (1 cycle): done=1.
  - read_en stays 0 throughout; xfer_data is unchanged.
- Invariants, checked by assertion:
  - read_en is one-hot or zero.
  - At most one of load_en, inc_en, clr_en is nonzero, and that one is one-hot.
  - load_en is never set without read_en set.
- req_valid dropping after accept has no effect. Request fields may change after accept.
- Reset mid-operation: all strobes drop asynchronously, no done pulse, state=IDLE.
- All outputs are registered (decoded from next-state); there are no combinational paths from req_* to strobes.

Decomposition:
- Shared package bus_pkg holds:
  - op encodings OP_MOVE=2'b00, OP_INC=2'b01, OP_CLR=2'b10;
  - state encoding IDLE, DRIVE, LOAD, UNARY, DONE, ERR;
  - the bus width constant.
- One sub-module, onehot_dec (index+enable -> NREG one-hot vector, zero when out of range). It is instantiated four times for the strobe vectors.

Test Plan:
- Reset with req_valid=1 -> all strobes 0, req_ready=1 after release, xfer_data=0.
- MOVE src=2 dst=5 with register model 2 holding 16'hBEEF:
  - read_en=8'h04 for 2 cycles, load_en=8'h20 in the second;
  - done pulses 3 cycles after accept;
  - reg5=16'hBEEF and xfer_data=16'hBEEF.
- INC dst=1 (reg1=16'hFFFF) -> inc_en=8'h02 for 1 cycle, done next cycle, reg1=16'h0000 (wrap), read_en stays 0.
- MOVE src=3 dst=3, then op=11 -> each gives an err pulse 1 cycle after accept, no strobes, back to IDLE, xfer_data unchanged.
- Back-to-back MOVE requests with req_valid held high -> second accepted only when req_ready rises after DONE; never two read_en bits high; bus never driven by two registers.
- rst_n low during LOAD of MOVE 0->7 -> strobes clear immediately, no done, reg7 not loaded on next edge, next request proceeds normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared encodings for the common-bus transfer sequencer: opcodes, FSM states, bus width.
package bus_pkg;

  localparam int BUS_W = 16;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_UNARY = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

endpackage

// File: rtl/onehot_dec.sv
// Index + enable to one-hot vector; all-zero when disabled or index >= NREG. Purely combinational.
module onehot_dec #(
  parameter int NREG = 8,
  parameter int IDXW = 3
) (
  input  logic            i_en,
  input  logic [IDXW-1:0] i_idx,
  output logic [NREG-1:0] o_vec
);

  always_comb begin
    o_vec = '0;
    for (int i = 0; i < NREG; i++) begin
      o_vec[i] = i_en && (int'(i_idx) == i);
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Common-bus transfer sequencer: MOVE done 3 cycles after accept, INC/CLR 2, reject err 1.
// Accepts one request at a time; req_ready is high only while idle, all outputs are flops.
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int IDXW  = 3,
  parameter int WIDTH = BUS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDXW-1:0]  req_src,
  input  logic [IDXW-1:0]  req_dst,
  output logic [NREG-1:0]  read_en,
  output logic [NREG-1:0]  load_en,
  output logic [NREG-1:0]  inc_en,
  output logic [NREG-1:0]  clr_en,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] xfer_data,
  output logic             done,
  output logic             err
);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [1:0]       r_op;
  logic [IDXW-1:0]  r_src;
  logic [IDXW-1:0]  r_dst;
  logic             r_ready;
  logic             r_done;
  logic             r_err;
  logic [NREG-1:0]  r_read_en;
  logic [NREG-1:0]  r_load_en;
  logic [NREG-1:0]  r_inc_en;
  logic [NREG-1:0]  r_clr_en;
  logic [WIDTH-1:0] r_xfer;

  logic             w_accept;
  logic             w_bad;
  logic [1:0]       w_op;
  logic [IDXW-1:0]  w_src;
  logic [IDXW-1:0]  w_dst;
  logic             w_rd_on;
  logic             w_ld_on;
  logic             w_inc_on;
  logic             w_clr_on;
  logic [NREG-1:0]  w_rd;
  logic [NREG-1:0]  w_ld;
  logic [NREG-1:0]  w_inc;
  logic [NREG-1:0]  w_clr;

  assign w_accept = req_valid && r_ready;

  always_comb begin
    w_bad = 1'b0;
    if (req_op == 2'b11) w_bad = 1'b1;
    if (int'(req_dst) >= NREG) w_bad = 1'b1;
    if (req_op == OP_MOVE && (int'(req_src) >= NREG || req_src == req_dst)) w_bad = 1'b1;
  end

  // Strobes are decoded from the next state, so fields must come from the request on the accept edge.
  assign w_op  = w_accept ? req_op  : r_op;
  assign w_src = w_accept ? req_src : r_src;
  assign w_dst = w_accept ? req_dst : r_dst;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_bad)                  w_next = ST_ERR;
          else if (req_op == OP_MOVE) w_next = ST_DRIVE;
          else                        w_next = ST_UNARY;
        end
      end
      ST_DRIVE: w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_DONE;
      ST_UNARY: w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_rd_on  = (w_next == ST_DRIVE) || (w_next == ST_LOAD);
  assign w_ld_on  = (w_next == ST_LOAD);
  assign w_inc_on = (w_next == ST_UNARY) && (w_op == OP_INC);
  assign w_clr_on = (w_next == ST_UNARY) && (w_op == OP_CLR);

  onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_rd  (.i_en(w_rd_on),  .i_idx(w_src), .o_vec(w_rd));
  onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_ld  (.i_en(w_ld_on),  .i_idx(w_dst), .o_vec(w_ld));
  onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_inc (.i_en(w_inc_on), .i_idx(w_dst), .o_vec(w_inc));
  onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_clr (.i_en(w_clr_on), .i_idx(w_dst), .o_vec(w_clr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MOVE;
      r_src     <= '0;
      r_dst     <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_read_en <= '0;
      r_load_en <= '0;
      r_inc_en  <= '0;
      r_clr_en  <= '0;
      r_xfer    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op  <= req_op;
        r_src <= req_src;
        r_dst <= req_dst;
      end
      r_ready   <= (w_next == ST_IDLE);
      r_done    <= (w_next == ST_DONE);
      r_err     <= (w_next == ST_ERR);
      r_read_en <= w_rd;
      r_load_en <= w_ld;
      r_inc_en  <= w_inc;
      r_clr_en  <= w_clr;
      // The source register drives the bus throughout LOAD; capture alongside the destination.
      if (r_state == ST_LOAD) r_xfer <= bus_in;
    end
  end

  assign req_ready = r_ready;
  assign read_en   = r_read_en;
  assign load_en   = r_load_en;
  assign inc_en    = r_inc_en;
  assign clr_en    = r_clr_en;
  assign xfer_data = r_xfer;
  assign done      = r_done;
  assign err       = r_err;

  a_read_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(read_en));
  a_dst_excl: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({|load_en, |inc_en, |clr_en}) && $onehot0(load_en) && $onehot0(inc_en) && $onehot0(clr_en));
  a_load_needs_read: assert property (@(posedge clk) disable iff (!rst_n) (|load_en) |-> (|read_en));

endmodule
